mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single-port line memory between the instruction cache (line refills) and the data cache (line refills and dirty-line writebacks).
Sits between both caches and the memory instance inside the processor top level, and replaces the current direct iCache-to-memory connection.
Serialises transactions, so that exactly one is outstanding at a time.
Routes each response back only to the requester that owns the current grant.

Parameters:
ARCH_BITS, 32, address width.
LINE_BITS, 128, memory line width.
TURNAROUND, 1, idle cycles inserted after each completed transaction (0..3).

Ports:
clk  in  1  clock
rst  in  1  reset
iReadReq  in  1  iCache line read request (level, held until iDataValid)
iReadAddr  in  ARCH_BITS  iCache read address
iData  out  LINE_BITS  line returned to iCache
iDataValid  out  1  one-cycle pulse, iData valid
dReadReq  in  1  dCache line read request (level, held until dDataValid)
dReadAddr  in  ARCH_BITS  dCache read address
dData  out  LINE_BITS  line returned to dCache
dDataValid  out  1  one-cycle pulse, dData valid
dWriteReq  in  1  dCache writeback request (level, held until dWriteDone)
dWriteAddr  in  ARCH_BITS  writeback address
dWriteData  in  LINE_BITS  writeback line
dWriteDone  out  1  one-cycle pulse, writeback complete
memReadAddr  out  ARCH_BITS  memory read address
memReadReq  out  1  memory read request
memWriteAddr  out  ARCH_BITS  memory write address
memWriteData  out  LINE_BITS  memory write data
memWriteEnable  out  1  memory write enable
memData  in  LINE_BITS  memory read data
memDataValid  in  1  memory read complete
memWriteDone  in  1  memory write complete

Behaviour:
Reset:
- rst is synchronous and active-high; clk is the clock.
- On rst, all *Valid/*Done outputs, memReadReq and memWriteEnable are 0.
- On rst, the address and data outputs are 0, the FSM is in IDLE, and lastGrant is DCACHE (so icache wins the first tie).
- rst asserted mid-transaction aborts it: no response pulse is produced, and the memory request drops on the next edge.

FSM states: IDLE, IREAD, DREAD, DWRITE, TURN.
- IDLE, arbitration on registered request inputs, decided in one cycle:
  - dWriteReq has top priority, and dWriteReq with dReadReq issues the write first (writeback before refill).
  - Otherwise, if iReadReq and dReadReq are both high, grant the requester not equal to lastGrant (round-robin).
  - A single request is granted directly.
  - Next state is IREAD, DREAD or DWRITE. lastGrant is updated on grant (DWRITE counts as DCACHE).
- IREAD/DREAD:
  - memReadAddr is latched from the granted address on entry and held stable for the whole transaction.
  - memReadReq is 1.
  - On memDataValid: the owner's data output <= memData, the owner's valid pulses for exactly 1 cycle, and the state goes to TURN (or IDLE if TURNAROUND=0).
- DWRITE:
  - memWriteAddr and memWriteData are latched on entry; memWriteEnable is 1.
  - On memWriteDone: dWriteDone pulses for 1 cycle, then the FSM goes to TURN/IDLE.
- TURN:
  - memReadReq=0 and memWriteEnable=0.
  - A counter runs TURNAROUND cycles, then the FSM goes to IDLE.
  - Requests are ignored while in TURN.

Latency and timing rules:
- Minimum latency is request seen in IDLE -> memory request asserted the next cycle.
- The response pulse is registered: it appears one cycle after memDataValid/memWriteDone.
- Requesters may drop their request in the cycle their pulse is seen. A request still high in IDLE after that is treated as a new request.
- memDataValid/memWriteDone arriving in a state that does not expect them are ignored.
- memReadReq and memWriteEnable are never high in the same cycle.
- No response is ever routed to a non-owner.
- iData/dData hold their last value between pulses.
- A request that drops before being granted is simply not served; a request that drops mid-transaction does not abort it.
- Fairness: with both read requesters continuously active, grants alternate I, D, I, D…

Test Plan:
- iReadReq=1, addr 0x00001000, memory returns 0xA5… after 3 cycles -> memReadReq=1 with memReadAddr=0x1000 for 3 cycles; iDataValid pulses once with the line; dDataValid stays 0.
- iReadReq and dReadReq both high from reset (addr 0x1000 / 0x8000) -> icache is served first, then dcache after TURN. Holding both for 4 transactions gives the grant order I, D, I, D.
- dWriteReq and dReadReq high together (write addr 0x8010, data 0x1234…) -> DWRITE first with memWriteEnable=1 and the correct data; dWriteDone pulses; then DREAD for the refill.
- iReadReq mid-IREAD plus dWriteReq rising -> the iCache transaction completes uninterrupted; DWRITE starts after TURN; memReadReq and memWriteEnable are never both 1.
- rst pulsed 2 cycles into a DREAD -> the next cycle has memReadReq=0 and no dDataValid. A late memDataValid is ignored, and the FSM is in IDLE.
- TURNAROUND=0 build, back-to-back iReadReq -> the second memReadReq asserts the cycle after the first iDataValid.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the shared line memory and mem_arbiter.
// The arbiter takes the slave view: it receives cache requests and drives the memory.
interface mem_arbiter_if #(
    parameter int ARCH_BITS = 32,
    parameter int LINE_BITS = 128
);
    // iCache side
    logic                 iReadReq;
    logic [ARCH_BITS-1:0] iReadAddr;
    logic [LINE_BITS-1:0] iData;
    logic                 iDataValid;
    // dCache side
    logic                 dReadReq;
    logic [ARCH_BITS-1:0] dReadAddr;
    logic [LINE_BITS-1:0] dData;
    logic                 dDataValid;
    logic                 dWriteReq;
    logic [ARCH_BITS-1:0] dWriteAddr;
    logic [LINE_BITS-1:0] dWriteData;
    logic                 dWriteDone;
    // memory side
    logic [ARCH_BITS-1:0] memReadAddr;
    logic                 memReadReq;
    logic [ARCH_BITS-1:0] memWriteAddr;
    logic [LINE_BITS-1:0] memWriteData;
    logic                 memWriteEnable;
    logic [LINE_BITS-1:0] memData;
    logic                 memDataValid;
    logic                 memWriteDone;

    modport slave (
        input  iReadReq, iReadAddr,
        output iData, iDataValid,
        input  dReadReq, dReadAddr, dWriteReq, dWriteAddr, dWriteData,
        output dData, dDataValid, dWriteDone,
        output memReadAddr, memReadReq, memWriteAddr, memWriteData, memWriteEnable,
        input  memData, memDataValid, memWriteDone
    );

    modport master (
        output iReadReq, iReadAddr,
        input  iData, iDataValid,
        output dReadReq, dReadAddr, dWriteReq, dWriteAddr, dWriteData,
        input  dData, dDataValid, dWriteDone,
        input  memReadAddr, memReadReq, memWriteAddr, memWriteData, memWriteEnable,
        output memData, memDataValid, memWriteDone
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port line memory between iCache refills and dCache
// refills/writebacks. One transaction outstanding at a time; responses are
// routed only to the current grant owner, followed by TURNAROUND idle cycles.
module mem_arbiter #(
    parameter int ARCH_BITS  = 32,
    parameter int LINE_BITS  = 128,
    parameter int TURNAROUND = 1
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IREAD, DREAD, DWRITE, TURN} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    // With no turnaround a finished transaction returns straight to arbitration.
    localparam state_t     AFTER_XFER = (TURNAROUND == 0) ? IDLE : TURN;
    localparam logic [1:0] TURN_LAST  = (TURNAROUND == 0) ? 2'd0 : 2'(TURNAROUND - 1);

    state_t               state_q, state_d;
    grant_t               last_q, last_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [ARCH_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [ARCH_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [LINE_BITS-1:0] wr_data_q, wr_data_d;
    logic [LINE_BITS-1:0] idata_q, idata_d;
    logic [LINE_BITS-1:0] ddata_q, ddata_d;
    logic                 ivalid_q, ivalid_d;
    logic                 dvalid_q, dvalid_d;
    logic                 wdone_q, wdone_d;

    // Arbitration, transaction tracking and registered response capture.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        idata_d   = idata_q;
        ddata_d   = ddata_q;
        ivalid_d  = 1'b0;
        dvalid_d  = 1'b0;
        wdone_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Writeback beats everything; reads tie-break away from the last owner.
                if (bus.dWriteReq) begin
                    state_d   = DWRITE;
                    last_d    = GRANT_D;
                    wr_addr_d = bus.dWriteAddr;
                    wr_data_d = bus.dWriteData;
                end else if (bus.iReadReq && (!bus.dReadReq || last_q == GRANT_D)) begin
                    state_d   = IREAD;
                    last_d    = GRANT_I;
                    rd_addr_d = bus.iReadAddr;
                end else if (bus.dReadReq) begin
                    state_d   = DREAD;
                    last_d    = GRANT_D;
                    rd_addr_d = bus.dReadAddr;
                end
            end
            IREAD: begin
                if (bus.memDataValid) begin
                    idata_d  = bus.memData;
                    ivalid_d = 1'b1;
                    state_d  = AFTER_XFER;
                end
            end
            DREAD: begin
                if (bus.memDataValid) begin
                    ddata_d  = bus.memData;
                    dvalid_d = 1'b1;
                    state_d  = AFTER_XFER;
                end
            end
            DWRITE: begin
                if (bus.memWriteDone) begin
                    wdone_d = 1'b1;
                    state_d = AFTER_XFER;
                end
            end
            TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= GRANT_D;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            idata_q   <= '0;
            ddata_q   <= '0;
            ivalid_q  <= 1'b0;
            dvalid_q  <= 1'b0;
            wdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            idata_q   <= idata_d;
            ddata_q   <= ddata_d;
            ivalid_q  <= ivalid_d;
            dvalid_q  <= dvalid_d;
            wdone_q   <= wdone_d;
        end
    end

    // Memory strobes decode directly from the state flop, so they are mutually exclusive.
    assign bus.memReadReq     = (state_q == IREAD) || (state_q == DREAD);
    assign bus.memWriteEnable = (state_q == DWRITE);
    assign bus.memReadAddr    = rd_addr_q;
    assign bus.memWriteAddr   = wr_addr_q;
    assign bus.memWriteData   = wr_data_q;
    assign bus.iData          = idata_q;
    assign bus.iDataValid     = ivalid_q;
    assign bus.dData          = ddata_q;
    assign bus.dDataValid     = dvalid_q;
    assign bus.dWriteDone     = wdone_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: two requester processes and a memory
// model drive the bus; a monitor predicts every grant from the arbitration
// rules and pops expected responses from per-requester scoreboard queues.
module tb_mem_arbiter;
    localparam int TA = 1;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ARCH_BITS(32), .LINE_BITS(128)) bus ();
    mem_arbiter_if #(.ARCH_BITS(32), .LINE_BITS(128)) if0 ();

    mem_arbiter #(.ARCH_BITS(32), .LINE_BITS(128), .TURNAROUND(TA)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.ARCH_BITS(32), .LINE_BITS(128), .TURNAROUND(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0));

    // Stimulus sources, selected between random and directed phases.
    logic         dir_mode;
    logic         rnd_ireq, rnd_dreq, rnd_dwreq;
    logic [31:0]  rnd_iaddr, rnd_daddr, rnd_dwaddr;
    logic [127:0] rnd_dwdata;
    logic         dir_ireq, dir_dreq;
    logic [31:0]  dir_iaddr, dir_daddr;
    logic         auto_valid, auto_done, man_valid;
    logic [127:0] auto_data, man_data;
    logic         start_rand, i_done, d_done;

    assign bus.iReadReq     = dir_mode ? dir_ireq  : rnd_ireq;
    assign bus.iReadAddr    = dir_mode ? dir_iaddr : rnd_iaddr;
    assign bus.dReadReq     = dir_mode ? dir_dreq  : rnd_dreq;
    assign bus.dReadAddr    = dir_mode ? dir_daddr : rnd_daddr;
    assign bus.dWriteReq    = dir_mode ? 1'b0      : rnd_dwreq;
    assign bus.dWriteAddr   = rnd_dwaddr;
    assign bus.dWriteData   = rnd_dwdata;
    assign bus.memDataValid = dir_mode ? man_valid : auto_valid;
    assign bus.memWriteDone = dir_mode ? 1'b0      : auto_done;
    assign bus.memData      = dir_mode ? man_data  : auto_data;

    // Scoreboard
    logic [127:0] exp_i[$];
    logic [127:0] exp_d[$];
    int           exp_wdone = 0;

    // Reference memory (requester view) and memory-device contents (DUT view).
    logic [127:0] ref_mem   [logic [31:0]];
    logic [127:0] mem_store [logic [31:0]];

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a, ~a, a ^ 32'hA5A5_A5A5, a + 32'h0000_1234};
    endfunction

    function automatic logic [127:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : line_of(a);
    endfunction

    function automatic logic [127:0] mem_rd(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : line_of(a);
    endfunction

    task automatic chk(input bit ok, input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // iCache requester: random refills, sometimes holding the request for a new line.
    initial begin : icache
        bit          keep;
        logic [31:0] a;
        bit          got;
        rnd_ireq = 1'b0; rnd_iaddr = '0; keep = 1'b0;
        wait (start_rand);
        for (int n = 0; n < 40; n++) begin
            if (!keep) repeat ($urandom_range(0, 2)) tick();
            a = 32'h0000_1000 | (32'($urandom_range(0, 63)) << 4);
            rnd_iaddr = a;
            rnd_ireq  = 1'b1;
            exp_i.push_back(line_of(a));
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                tick();
                got = bus.iDataValid;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL i_timeout: got no iDataValid expected pulse for %h", a);
            end
            keep = got && (n < 39) && ($urandom_range(0, 3) == 0);
            if (!keep) rnd_ireq = 1'b0;
        end
        i_done = 1'b1;
    end

    // dCache requester: read, writeback, or writeback together with refill.
    initial begin : dcache
        int           kind;
        logic [31:0]  a;
        logic [127:0] d;
        rnd_dreq = 1'b0; rnd_dwreq = 1'b0; rnd_daddr = '0; rnd_dwaddr = '0; rnd_dwdata = '0;
        wait (start_rand);
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            kind = int'($urandom_range(0, 2));
            if (kind != 0) begin
                a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 4);
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                rnd_dwaddr = a; rnd_dwdata = d; rnd_dwreq = 1'b1;
                ref_mem[a] = d;
                exp_wdone++;
            end
            if (kind != 1) begin
                a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 4);
                rnd_daddr = a; rnd_dreq = 1'b1;
                exp_d.push_back(ref_rd(a));
            end
            for (int c = 0; c < 400 && (rnd_dreq || rnd_dwreq); c++) begin
                tick();
                if (bus.dDataValid) rnd_dreq = 1'b0;
                if (bus.dWriteDone) rnd_dwreq = 1'b0;
            end
            if (rnd_dreq || rnd_dwreq) begin
                checks++; errors++;
                $display("FAIL d_timeout: got req=%b wreq=%b expected both served", rnd_dreq, rnd_dwreq);
                rnd_dreq = 1'b0; rnd_dwreq = 1'b0;
            end
        end
        d_done = 1'b1;
    end

    // Memory device: random latency, plus stray strobes of the unexpected kind.
    initial begin : memory_model
        bit pend;
        int cnt;
        auto_valid = 1'b0; auto_done = 1'b0; auto_data = '0;
        pend = 1'b0; cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            auto_valid = 1'b0;
            auto_done  = 1'b0;
            if (rst || !(bus.memReadReq || bus.memWriteEnable)) begin
                pend = 1'b0;
            end else begin
                if (!pend) begin
                    pend = 1'b1;
                    cnt  = int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    if (bus.memReadReq) begin
                        auto_data  = mem_rd(bus.memReadAddr);
                        auto_valid = 1'b1;
                        auto_done  = ($urandom_range(0, 3) == 0);
                    end else begin
                        mem_store[bus.memWriteAddr] = bus.memWriteData;
                        auto_done = 1'b1;
                        if ($urandom_range(0, 3) == 0) begin
                            auto_valid = 1'b1;
                            auto_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                        end
                    end
                    cnt = -1;
                end else if (cnt > 0) begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: predicts each grant from the previous cycle's requests, checks
    // turnaround gaps, latency, address stability and response routing.
    initial begin : monitor
        logic         p_ir, p_dr, p_dw, p_act, p_idle, last_d, act_r, act_w, act;
        logic [31:0]  p_ia, p_da, p_wa, hold_ra, hold_wa;
        logic [127:0] p_wd, e;
        int           low_run;
        p_ir = 0; p_dr = 0; p_dw = 0; p_act = 0; p_idle = 1; last_d = 1;
        p_ia = '0; p_da = '0; p_wa = '0; p_wd = '0; hold_ra = '0; hold_wa = '0;
        low_run = 1000;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_ir = 0; p_dr = 0; p_dw = 0; p_act = 0; p_idle = 1; last_d = 1;
                low_run = 1000;
                continue;
            end
            act_r = bus.memReadReq;
            act_w = bus.memWriteEnable;
            act   = act_r || act_w;
            if (act_r && act_w) chk(1'b0, "rd_wr_exclusive", {act_r, act_w}, 2'b00);

            if (bus.iDataValid) begin
                if (exp_i.size() == 0) chk(1'b0, "i_unexpected", bus.iData, '0);
                else begin e = exp_i.pop_front(); chk(bus.iData == e, "i_data", bus.iData, e); end
            end
            if (bus.dDataValid) begin
                if (exp_d.size() == 0) chk(1'b0, "d_unexpected", bus.dData, '0);
                else begin e = exp_d.pop_front(); chk(bus.dData == e, "d_data", bus.dData, e); end
            end
            if (bus.dWriteDone) begin
                chk(exp_wdone > 0, "wdone_unexpected", 128'(exp_wdone), 1);
                if (exp_wdone > 0) exp_wdone--;
            end

            if (act && !p_act) begin
                chk(p_idle, "turn_gap", 128'(low_run), TA + 1);
                if (p_dw) begin
                    chk(act_w && bus.memWriteAddr == p_wa, "grant_w_addr", bus.memWriteAddr, p_wa);
                    chk(bus.memWriteData == p_wd, "grant_w_data", bus.memWriteData, p_wd);
                    last_d = 1;
                end else if (p_ir && (!p_dr || last_d)) begin
                    chk(act_r && bus.memReadAddr == p_ia, "grant_i", bus.memReadAddr, p_ia);
                    last_d = 0;
                end else if (p_dr) begin
                    chk(act_r && bus.memReadAddr == p_da, "grant_d", bus.memReadAddr, p_da);
                    last_d = 1;
                end else begin
                    chk(1'b0, "spurious_grant", {act_r, act_w}, 2'b00);
                end
                hold_ra = bus.memReadAddr;
                hold_wa = bus.memWriteAddr;
            end else if (act && p_act) begin
                if (act_r) chk(bus.memReadAddr == hold_ra, "rd_addr_stable", bus.memReadAddr, hold_ra);
                if (act_w) chk(bus.memWriteAddr == hold_wa, "wr_addr_stable", bus.memWriteAddr, hold_wa);
            end
            if (p_idle && (p_ir || p_dr || p_dw)) chk(act, "grant_latency", act, 1'b1);

            if (act) low_run = 0;
            else if (low_run < 1000) low_run++;
            p_act  = act;
            p_idle = !act && (low_run >= TA + 1);
            p_ir = bus.iReadReq;  p_ia = bus.iReadAddr;
            p_dr = bus.dReadReq;  p_da = bus.dReadAddr;
            p_dw = bus.dWriteReq; p_wa = bus.dWriteAddr; p_wd = bus.dWriteData;
        end
    end

    // Sequencer: reset checks, random phase, directed abort and zero-turnaround cases.
    initial begin : main
        bit finished;
        rst = 1'b1; dir_mode = 1'b0; start_rand = 1'b0; i_done = 1'b0; d_done = 1'b0;
        dir_ireq = 1'b0; dir_dreq = 1'b0; dir_iaddr = '0; dir_daddr = '0;
        man_valid = 1'b0; man_data = '0;
        if0.iReadReq = 1'b0; if0.iReadAddr = '0; if0.dReadReq = 1'b0; if0.dReadAddr = '0;
        if0.dWriteReq = 1'b0; if0.dWriteAddr = '0; if0.dWriteData = '0;
        if0.memData = '0; if0.memDataValid = 1'b0; if0.memWriteDone = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(bus.iDataValid == 0 && bus.dDataValid == 0 && bus.dWriteDone == 0, "rst_pulses",
            {bus.iDataValid, bus.dDataValid, bus.dWriteDone}, 3'b000);
        chk(bus.memReadReq == 0 && bus.memWriteEnable == 0, "rst_strobes",
            {bus.memReadReq, bus.memWriteEnable}, 2'b00);
        chk(bus.iData == '0, "rst_idata", bus.iData, '0);
        chk(bus.dData == '0, "rst_ddata", bus.dData, '0);
        chk(bus.memReadAddr == '0 && bus.memWriteAddr == '0, "rst_addr",
            {bus.memReadAddr, bus.memWriteAddr}, '0);
        chk(bus.memWriteData == '0, "rst_wdata", bus.memWriteData, '0);
        tick();
        rst = 1'b0;

        // Random traffic
        start_rand = 1'b1;
        finished = 1'b0;
        for (int c = 0; c < 40000 && !finished; c++) begin
            tick();
            finished = i_done && d_done;
        end
        chk(finished, "random_done", finished, 1'b1);
        repeat (10) tick();
        chk(exp_i.size() == 0 && exp_d.size() == 0 && exp_wdone == 0, "random_drain",
            {32'(exp_i.size()), 32'(exp_d.size()), 32'(exp_wdone)}, '0);

        // Reset two cycles into a dCache refill aborts it silently.
        dir_mode = 1'b1;
        repeat (4) tick();
        dir_daddr = 32'h8000_0040; dir_dreq = 1'b1;
        finished = 1'b0;
        for (int c = 0; c < 20 && !finished; c++) begin
            tick();
            finished = bus.memReadReq;
        end
        chk(finished, "abort_dread_start", finished, 1'b1);
        tick();
        rst = 1'b1; dir_dreq = 1'b0;
        tick();
        rst = 1'b0;
        chk(bus.memReadReq == 0, "abort_req_drop", bus.memReadReq, 1'b0);
        chk(bus.dDataValid == 0, "abort_no_pulse", bus.dDataValid, 1'b0);
        man_data = 128'hDEAD_BEEF; man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        chk(bus.dDataValid == 0 && bus.memReadReq == 0, "late_valid_ignored",
            {bus.dDataValid, bus.memReadReq}, 2'b00);
        // Back in IDLE: a fresh request is granted on the next cycle.
        dir_iaddr = 32'h0000_2000; dir_ireq = 1'b1;
        exp_i.push_back(line_of(32'h0000_2000));
        tick();
        chk(bus.memReadReq == 1 && bus.memReadAddr == 32'h0000_2000, "post_abort_grant",
            bus.memReadAddr, 32'h0000_2000);
        man_data = line_of(32'h0000_2000); man_valid = 1'b1;
        tick();
        man_valid = 1'b0; dir_ireq = 1'b0;
        chk(bus.iDataValid == 1, "post_abort_ivalid", bus.iDataValid, 1'b1);

        // Zero-turnaround build: held request re-granted the cycle after the pulse.
        if0.iReadAddr = 32'h0000_3000; if0.iReadReq = 1'b1;
        tick();
        chk(if0.memReadReq == 1 && if0.memReadAddr == 32'h0000_3000, "t0_first_grant",
            if0.memReadAddr, 32'h0000_3000);
        tick();
        if0.memData = line_of(32'h0000_3000); if0.memDataValid = 1'b1;
        tick();
        if0.memDataValid = 1'b0;
        chk(if0.iDataValid == 1 && if0.memReadReq == 0, "t0_pulse1",
            {if0.iDataValid, if0.memReadReq}, 2'b10);
        chk(if0.iData == line_of(32'h0000_3000), "t0_data1", if0.iData, line_of(32'h0000_3000));
        if0.iReadAddr = 32'h0000_3010;
        tick();
        chk(if0.memReadReq == 1 && if0.memReadAddr == 32'h0000_3010, "t0_back_to_back",
            if0.memReadAddr, 32'h0000_3010);
        chk(if0.iDataValid == 0, "t0_single_pulse", if0.iDataValid, 1'b0);
        if0.memData = line_of(32'h0000_3010); if0.memDataValid = 1'b1;
        tick();
        if0.memDataValid = 1'b0; if0.iReadReq = 1'b0;
        chk(if0.iDataValid == 1 && if0.iData == line_of(32'h0000_3010), "t0_data2",
            if0.iData, line_of(32'h0000_3010));
        chk(if0.dDataValid == 0, "t0_no_dvalid", if0.dDataValid, 1'b0);

        repeat (5) tick();
        chk(exp_i.size() == 0 && exp_d.size() == 0 && exp_wdone == 0, "final_drain",
            {32'(exp_i.size()), 32'(exp_d.size()), 32'(exp_wdone)}, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
